// File: rtl/axi_write_slave_burst_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_write_slave_burst_if
//  Description : AXI3 write-channel bundle (AW, W, B) for the burst write
//                slave. The master modport drives address, data and BREADY;
//                the slave modport drives the ready and response signals.
//  Ports       : AW* address channel, W* data channel, B* response channel
//  Revision    : 1.0  initial release
// ============================================================================
interface axi_write_slave_burst_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    // Address channel
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [3:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic [1:0]              AWLOCK;
    logic [3:0]              AWCACHE;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    // Data channel
    logic [ID_WIDTH-1:0]     WID;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    // Response channel
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface
`default_nettype wire

// File: rtl/axi_write_slave_burst.sv
`default_nettype none
// ============================================================================
//  Module      : axi_write_slave_burst
//  Description : AXI3 write slave. Takes one AW transaction at a time,
//                generates per-beat addresses for FIXED/INCR/WRAP bursts,
//                forwards strobed beats to a memory write port (zero latency,
//                backpressured by mem_ready) and returns a B response.
//                Illegal bursts are fully consumed but never written and end
//                with SLVERR.
//  Ports       : ACLK, ARESET (sync, active high)
//                axi        - AW/W/B channels (slave modport)
//                mem_ready  - memory accepts a beat this cycle
//                mem_wr_en / mem_addr / mem_wdata / mem_wstrb - memory write
//  Options     : define AXI_WSLV_PROTCHK_EN to flag WLAST/WID protocol
//                violations as a sticky SLVERR that stops further writes.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_write_slave_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_BYTES  = 4096
) (
    input  wire logic                    ACLK,
    input  wire logic                    ARESET,
    axi_write_slave_burst_if.slave       axi,
    input  wire logic                    mem_ready,
    output logic                         mem_wr_en,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [DATA_WIDTH/8-1:0]      mem_wstrb
);

    localparam int c_max_size = $clog2(DATA_WIDTH/8);
    // Wide enough that addr + 16 beats * 128 bytes cannot overflow.
    localparam int c_ext_w    = ADDR_WIDTH + 13;
    localparam logic [c_ext_w-1:0] c_mem_bytes = c_ext_w'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_awready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [3:0]            r_beat_cnt;
    logic                  r_err;

    // ------------------------------------------------------------------
    // AW-time legality checks, evaluated on the raw channel fields
    // ------------------------------------------------------------------
    logic [c_ext_w-1:0] w_aw_addr_ext;
    logic [c_ext_w-1:0] w_aw_bytes_ext;
    logic [c_ext_w-1:0] w_aw_span;
    logic [c_ext_w-1:0] w_aw_end;
    logic               w_aw_wrap_len_ok;
    logic               w_aw_err;
    logic               w_aw_hs;

    assign w_aw_addr_ext    = c_ext_w'(axi.AWADDR);
    assign w_aw_bytes_ext   = c_ext_w'(1) << axi.AWSIZE;
    assign w_aw_span        = c_ext_w'({1'b0, axi.AWLEN} + 5'd1) << axi.AWSIZE;
    assign w_aw_end         = w_aw_addr_ext + w_aw_span - c_ext_w'(1);
    assign w_aw_wrap_len_ok = (axi.AWLEN == 4'd1) || (axi.AWLEN == 4'd3) ||
                              (axi.AWLEN == 4'd7) || (axi.AWLEN == 4'd15);

    assign w_aw_err = (axi.AWSIZE > 3'(c_max_size))                                   ||
                      (axi.AWBURST == 2'b11)                                          ||
                      ((axi.AWBURST == 2'b10) && !w_aw_wrap_len_ok)                   ||
                      ((axi.AWBURST == 2'b10) &&
                       ((w_aw_addr_ext & (w_aw_bytes_ext - c_ext_w'(1))) != '0))      ||
                      (w_aw_addr_ext >= c_mem_bytes)                                  ||
                      ((axi.AWBURST == 2'b01) && (w_aw_end >= c_mem_bytes));

    // AWREADY is only ever high in IDLE, so it alone qualifies the handshake.
    assign w_aw_hs = axi.AWVALID && r_awready;

    // ------------------------------------------------------------------
    // Next beat address
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_incr_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    assign w_bytes     = ADDR_WIDTH'(1) << r_size;
    assign w_wrap_mask = (ADDR_WIDTH'({1'b0, r_len} + 5'd1) << r_size) - ADDR_WIDTH'(1);
    assign w_incr_addr = r_addr + w_bytes;

    always_comb begin
        w_next_addr = r_addr;
        case (r_burst)
            2'b01:   w_next_addr = w_incr_addr;
            2'b10:   w_next_addr = (r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
            default: w_next_addr = r_addr;   // FIXED, and reserved (never written)
        endcase
    end

    // ------------------------------------------------------------------
    // Data beat acceptance and write strobe
    // ------------------------------------------------------------------
    logic w_wready;
    logic w_beat;
    logic w_last_beat;
    logic w_proto_bad;

    assign w_wready    = (r_state == S_DATA) && mem_ready;
    assign w_beat      = w_wready && axi.WVALID;
    assign w_last_beat = (r_beat_cnt == r_len);

`ifdef AXI_WSLV_PROTCHK_EN
    assign w_proto_bad = w_beat && ((axi.WLAST != w_last_beat) || (axi.WID != r_id));
`else
    assign w_proto_bad = 1'b0;
`endif

    // The offending beat itself is suppressed, not just the ones after it.
    assign mem_wr_en = w_beat && !r_err && !w_proto_bad;
    assign mem_addr  = r_addr;
    assign mem_wdata = axi.WDATA;
    assign mem_wstrb = axi.WSTRB;

    assign axi.AWREADY = r_awready;
    assign axi.WREADY  = w_wready;
    assign axi.BVALID  = r_bvalid;
    assign axi.BRESP   = r_bresp;
    assign axi.BID     = r_bid;

    // Sideband fields that carry no meaning for this slave.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, axi.AWLOCK, axi.AWCACHE, axi.AWPROT, axi.WLAST, axi.WID};

    // ------------------------------------------------------------------
    // Control FSM with registered channel outputs
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state    <= S_IDLE;
            r_awready  <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_bid      <= '0;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_id       <= axi.AWID;
                        r_addr     <= axi.AWADDR;
                        r_len      <= axi.AWLEN;
                        r_size     <= axi.AWSIZE;
                        r_burst    <= axi.AWBURST;
                        r_beat_cnt <= '0;
                        r_err      <= w_aw_err;
                        r_awready  <= 1'b0;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        if (w_proto_bad) begin
                            r_err <= 1'b1;
                        end
                        // The AWLEN count, not WLAST, ends the burst.
                        if (w_last_beat) begin
                            r_bvalid <= 1'b1;
                            r_bid    <= r_id;
                            r_bresp  <= (r_err || w_proto_bad) ? 2'b10 : 2'b00;
                            r_state  <= S_RESP;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 4'd1;
                            r_addr     <= w_next_addr;
                        end
                    end
                end
                S_RESP: begin
                    if (axi.BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_slave_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_write_slave_burst
//  Description : Directed bench for axi_write_slave_burst. A transaction-level
//                model (expected beat-address list, error flags, response)
//                is compared against the DUT every cycle; literal address and
//                response lists pin the model for each directed burst.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_write_slave_burst;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int IW   = 4;
    localparam int MEMB = 4096;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic            mem_ready = 1'b0;
    logic            mem_wr_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;

    axi_write_slave_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) axi ();

    axi_write_slave_burst #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_BYTES(MEMB)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .axi       (axi),
        .mem_ready (mem_ready),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    bit              chk_en = 1'b0;
    bit              m_rst_cycle, m_awready, m_in_data, m_err, m_perr, m_bvalid;
    logic [IW-1:0]   m_id, m_bid;
    logic [1:0]      m_bresp;
    logic [AW-1:0]   m_addrs[$];

    logic [AW-1:0]   log_addr[$];
    logic [AW-1:0]   exp_q[$];
    logic [1:0]      log_bresp;
    logic [IW-1:0]   log_bid;
    int              log_nb, bvalid_cycles;

    function automatic bit model_err(input longint unsigned a, input int len,
                                     input int size, input int burst);
        longint unsigned bytes, span;
        bytes = 64'd1 << size;
        span  = 64'(len + 1) * bytes;
        model_err = 1'b0;
        if (bytes > 64'(DW / 8))                                     model_err = 1'b1;
        if (burst == 3)                                              model_err = 1'b1;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) model_err = 1'b1;
        if (burst == 2 && (a % bytes) != 0)                          model_err = 1'b1;
        if (a >= 64'(MEMB))                                          model_err = 1'b1;
        if (burst == 1 && a + span - 1 >= 64'(MEMB))                 model_err = 1'b1;
    endfunction

    // Address of beat i, from the burst definition: WRAP stays inside the
    // aligned window of (len+1)*bytes containing the start address.
    function automatic logic [AW-1:0] beat_addr(input longint unsigned a, input int len,
                                                input int size, input int burst, input int i);
        longint unsigned bytes, total, lower;
        bytes = 64'd1 << size;
        total = 64'(len + 1) * bytes;
        case (burst)
            1:       beat_addr = AW'(a + 64'(i) * bytes);
            2: begin
                lower     = a - (a % total);
                beat_addr = AW'(lower + ((a % total) + 64'(i) * bytes) % total);
            end
            default: beat_addr = AW'(a);
        endcase
    endfunction

    initial begin : p_compare
        logic exp_beat, bad, exp_wr, last;
        forever begin
            @(negedge ACLK);
            if (chk_en) begin
                if (m_rst_cycle) begin
                    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
                    chk("rst_bid",      64'(axi.BID), 64'(0));
                    chk("rst_bresp",    64'(axi.BRESP), 64'(0));
                end
                chk("awready", 64'(axi.AWREADY), 64'(m_awready));
                chk("wready",  64'(axi.WREADY), 64'(m_in_data && mem_ready));
                chk("bvalid",  64'(axi.BVALID), 64'(m_bvalid));
                if (m_bvalid) begin
                    chk("bid",   64'(axi.BID), 64'(m_bid));
                    chk("bresp", 64'(axi.BRESP), 64'(m_bresp));
                end
                exp_beat = m_in_data && mem_ready && axi.WVALID;
                last     = (m_addrs.size() == 1);
                bad      = 1'b0;
`ifdef AXI_WSLV_PROTCHK_EN
                if (exp_beat) bad = (axi.WLAST != last) || (axi.WID != m_id);
`endif
                exp_wr = exp_beat && !m_err && !m_perr && !bad;
                chk("mem_wr_en", 64'(mem_wr_en), 64'(exp_wr));
                if (exp_wr) begin
                    chk("mem_addr",  64'(mem_addr), 64'(m_addrs[0]));
                    chk("mem_wdata", 64'(mem_wdata), 64'(axi.WDATA));
                    chk("mem_wstrb", 64'(mem_wstrb), 64'(axi.WSTRB));
                end
                if (mem_wr_en) log_addr.push_back(mem_addr);
                if (axi.BVALID) bvalid_cycles++;
                if (axi.BVALID && axi.BREADY) begin
                    log_bresp = axi.BRESP;
                    log_bid   = axi.BID;
                    log_nb++;
                end
                // advance the model to the next cycle
                if (m_rst_cycle) begin
                    m_rst_cycle = 1'b0;
                    m_awready   = 1'b1;
                end else if (m_awready && axi.AWVALID) begin
                    m_id   = axi.AWID;
                    m_err  = model_err(64'(axi.AWADDR), int'(axi.AWLEN),
                                       int'(axi.AWSIZE), int'(axi.AWBURST));
                    m_perr = 1'b0;
                    m_addrs.delete();
                    for (int i = 0; i <= int'(axi.AWLEN); i++)
                        m_addrs.push_back(beat_addr(64'(axi.AWADDR), int'(axi.AWLEN),
                                                    int'(axi.AWSIZE), int'(axi.AWBURST), i));
                    m_in_data = 1'b1;
                    m_awready = 1'b0;
                end else if (exp_beat) begin
                    m_perr = m_perr || bad;
                    void'(m_addrs.pop_front());
                    if (m_addrs.size() == 0) begin
                        m_in_data = 1'b0;
                        m_bvalid  = 1'b1;
                        m_bid     = m_id;
                        m_bresp   = (m_err || m_perr) ? 2'b10 : 2'b00;
                    end
                end else if (m_bvalid && axi.BREADY) begin
                    m_bvalid  = 1'b0;
                    m_awready = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        chk_en      = 1'b0;
        ARESET      = 1'b1;
        axi.AWVALID = 1'b0;
        axi.WVALID  = 1'b0;
        repeat (n) tick();
        ARESET      = 1'b0;
        m_rst_cycle = 1'b1;
        m_awready   = 1'b0;
        m_in_data   = 1'b0;
        m_bvalid    = 1'b0;
        m_err       = 1'b0;
        m_perr      = 1'b0;
        m_bid       = '0;
        m_bresp     = 2'b00;
        m_addrs.delete();
        chk_en      = 1'b1;
    endtask

    task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int lastpos,
                             input logic [7:0] pat, input int plen,
                             input int bdelay, input int abort_at);
        int  k, guard;
        bit  done;
        log_addr.delete();
        log_nb        = 0;
        bvalid_cycles = 0;
        axi.BREADY    = (bdelay == 0);
        axi.AWID      = id;
        axi.AWADDR    = addr;
        axi.AWLEN     = len;
        axi.AWSIZE    = size;
        axi.AWBURST   = burst;
        axi.AWVALID   = 1'b1;
        done = 1'b0; guard = 0;
        while (!done && guard < 20) begin
            @(negedge ACLK);
            done = axi.AWREADY;
            tick();
            guard++;
        end
        chk("aw_handshake", 64'(done), 64'(1));
        axi.AWVALID = 1'b0;
        k = 0;
        for (int b = 0; b <= int'(len); b++) begin
            if (b == abort_at) begin
                axi.WVALID = 1'b0;
                return;
            end
            axi.WVALID = 1'b1;
            axi.WDATA  = {addr[15:0], 8'(b), 8'h5A};
            axi.WSTRB  = 4'hF ^ 4'(b);
            axi.WLAST  = (b == lastpos);
            axi.WID    = id;
            done = 1'b0; guard = 0;
            while (!done && guard < 20) begin
                mem_ready = pat[k % plen];
                k++;
                @(negedge ACLK);
                done = axi.WREADY;
                tick();
                guard++;
            end
            chk("w_handshake", 64'(done), 64'(1));
        end
        axi.WVALID = 1'b0;
        axi.WLAST  = 1'b0;
        mem_ready  = 1'b1;
        if (bdelay > 0) begin
            // a new address offered while the response waits must be ignored
            axi.AWVALID = 1'b1;
            axi.AWADDR  = 32'h0000_0800;
            axi.AWLEN   = 4'd0;
            repeat (bdelay) tick();
            axi.AWVALID = 1'b0;
            axi.BREADY  = 1'b1;
        end
        done = 1'b0; guard = 0;
        while (!done && guard < 20) begin
            @(negedge ACLK);
            done = axi.BVALID;
            tick();
            guard++;
        end
        chk("b_handshake", 64'(done), 64'(1));
        chk("b_count", 64'(log_nb), 64'(1));
    endtask

    task automatic chk_log(input string name);
        chk({name, "_nwr"}, 64'(log_addr.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_addr.size(); i++)
            chk({name, "_addr"}, 64'(log_addr[i]), 64'(exp_q[i]));
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [1:0]    bresp;
    } vec_t;

    vec_t vecs[8] = '{
        '{32'h0000_1000, 4'd0, 3'd2, 2'b01, 2'b10},  // start beyond range
        '{32'h0000_0FF8, 4'd1, 3'd2, 2'b01, 2'b00},  // INCR ends exactly at 0xFFF
        '{32'h0000_0FFC, 4'd1, 3'd2, 2'b01, 2'b10},  // INCR crosses 0x1000
        '{32'h0000_0040, 4'd1, 3'd2, 2'b11, 2'b10},  // reserved burst
        '{32'h0000_0040, 4'd2, 3'd2, 2'b10, 2'b10},  // WRAP length 3
        '{32'h0000_0042, 4'd1, 3'd2, 2'b10, 2'b10},  // WRAP misaligned
        '{32'h0000_0FFC, 4'd3, 3'd2, 2'b00, 2'b00},  // FIXED at top of range
        '{32'h0000_0FFE, 4'd0, 3'd1, 2'b01, 2'b00}   // halfword at 0xFFE
    };

    initial begin : p_main
        axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0;
        axi.AWBURST = '0; axi.AWLOCK = '0; axi.AWCACHE = '0; axi.AWPROT = '0;
        axi.AWVALID = 1'b0; axi.WID = '0; axi.WDATA = '0; axi.WSTRB = '0;
        axi.WLAST = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b1;

        do_reset(3);
        @(negedge ACLK);
        chk("awready_reset_cycle", 64'(axi.AWREADY), 64'(0));
        tick();
        @(negedge ACLK);
        chk("awready_after_reset", 64'(axi.AWREADY), 64'(1));
        tick();

        // INCR, 1-cycle response
        run_burst(4'h5, 32'h100, 4'd3, 3'd2, 2'b01, 3, 8'hFF, 1, 0, -1);
        exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
        chk_log("incr");
        chk("incr_bresp", 64'(log_bresp), 64'(0));
        chk("incr_bid", 64'(log_bid), 64'(5));
        chk("incr_bvalid_cycles", 64'(bvalid_cycles), 64'(1));

        // WRAP word
        run_burst(4'h3, 32'h38, 4'd3, 3'd2, 2'b10, 3, 8'hFF, 1, 0, -1);
        exp_q = '{32'h38, 32'h3C, 32'h30, 32'h34};
        chk_log("wrap");
        chk("wrap_bresp", 64'(log_bresp), 64'(0));

        // FIXED with mem_ready 1,0,1,0,1
        run_burst(4'h2, 32'h20, 4'd2, 3'd2, 2'b00, 2, 8'b0001_0101, 5, 0, -1);
        exp_q = '{32'h20, 32'h20, 32'h20};
        chk_log("fixed");

        // oversize beat
        run_burst(4'h4, 32'h0, 4'd1, 3'd3, 2'b01, 1, 8'hFF, 1, 0, -1);
        exp_q.delete();
        chk_log("oversize");
        chk("oversize_bresp", 64'(log_bresp), 64'(2));

        // BREADY held low 5 cycles
        run_burst(4'h9, 32'h300, 4'd1, 3'd2, 2'b01, 1, 8'hFF, 1, 5, -1);
        exp_q = '{32'h300, 32'h304};
        chk_log("bstall");
        chk("bstall_bid", 64'(log_bid), 64'(9));
        chk("bstall_bvalid_cycles", 64'(bvalid_cycles), 64'(6));

        // WLAST on beat 2 of 4
        run_burst(4'h7, 32'h200, 4'd3, 3'd2, 2'b01, 1, 8'hFF, 1, 0, -1);
`ifdef AXI_WSLV_PROTCHK_EN
        exp_q = '{32'h200};
        chk_log("early_wlast");
        chk("early_wlast_bresp", 64'(log_bresp), 64'(2));
`else
        exp_q = '{32'h200, 32'h204, 32'h208, 32'h20C};
        chk_log("early_wlast");
        chk("early_wlast_bresp", 64'(log_bresp), 64'(0));
`endif

        // byte WRAP of 8
        run_burst(4'h1, 32'h5, 4'd7, 3'd0, 2'b10, 7, 8'b0110_1011, 8, 0, -1);
        exp_q = '{32'h5, 32'h6, 32'h7, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4};
        chk_log("wrap8");

        // AW-time error table
        for (int i = 0; i < 8; i++) begin
            run_burst(4'(i), vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                      int'(vecs[i].len), 8'hFF, 1, 0, -1);
            chk("table_bresp", 64'(log_bresp), 64'(vecs[i].bresp));
            chk("table_nwr", 64'(log_addr.size()),
                64'((vecs[i].bresp == 2'b00) ? int'(vecs[i].len) + 1 : 0));
        end

        // WVALID while idle is not accepted
        log_addr.delete();
        axi.WVALID = 1'b1;
        mem_ready  = 1'b1;
        repeat (3) tick();
        axi.WVALID = 1'b0;
        chk("idle_wvalid_nwr", 64'(log_addr.size()), 64'(0));

        // reset in the middle of a burst
        run_burst(4'hA, 32'h400, 4'd3, 3'd2, 2'b01, 3, 8'hFF, 1, 0, 2);
        do_reset(1);
        @(negedge ACLK);
        chk("midrst_bvalid", 64'(axi.BVALID), 64'(0));
        chk("midrst_wready", 64'(axi.WREADY), 64'(0));
        tick();
        run_burst(4'hB, 32'h500, 4'd0, 3'd2, 2'b01, 0, 8'hFF, 1, 0, -1);
        exp_q = '{32'h500};
        chk_log("after_rst");
        chk("after_rst_bid", 64'(log_bid), 64'(11));

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
